// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file slave.
// Handshake rule for every channel: a beat transfers on the rising edge where
// VALID and READY are both 1; the source holds VALID and its payload stable
// until that edge, and READY may rise or fall freely while VALID is low.
interface axi4_lite_slave_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register bank. Register 0 reads back status_in and rejects
// writes; registers 1..NUM_REGS-1 are byte-writable control words exposed on
// regs_out with a one-cycle write pulse each. Write and read paths are two
// independent FSMs; their state is visible on the *_state_dbg outputs.
module axi4_lite_slave_regfile #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 16
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    axi4_lite_slave_regfile_if.slave s_axi,
    input  logic [31:0]            status_in,
    output logic [NUM_REGS*32-1:0] regs_out,
    output logic [NUM_REGS-1:0]    reg_wr_pulse,
    output logic                   w_state_dbg,
    output logic                   r_state_dbg
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

    // ---------------- write path state ----------------
    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;

    // ---------------- read path state ----------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    // ---------------- register bank ----------------
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic aw_fire, w_fire, ar_fire, commit;
    assign aw_fire = s_axi.S_AXI_AWVALID && awready_q;
    assign w_fire  = s_axi.S_AXI_WVALID  && wready_q;
    assign ar_fire = s_axi.S_AXI_ARVALID && arready_q;

    // The commit uses whichever copy of AW/W is current: the live bus beat if
    // it is being accepted on this edge, otherwise the one latched earlier.
    logic [ADDR_W-1:0] cm_addr;
    logic [31:0]       cm_data;
    logic [3:0]        cm_strb;
    logic [IDX_W-1:0]  cm_idx;
    logic              cm_ok;
    assign cm_addr = aw_fire ? s_axi.S_AXI_AWADDR : awaddr_q;
    assign cm_data = w_fire  ? s_axi.S_AXI_WDATA  : wdata_q;
    assign cm_strb = w_fire  ? s_axi.S_AXI_WSTRB  : wstrb_q;
    assign cm_idx  = cm_addr[IDX_W+1:2];
    assign cm_ok   = !(|cm_addr[ADDR_W-1:IDX_W+2]) && (cm_idx != '0);

    logic [IDX_W-1:0] ar_idx;
    logic             ar_oor;
    assign ar_idx = s_axi.S_AXI_ARADDR[IDX_W+1:2];
    assign ar_oor = |s_axi.S_AXI_ARADDR[ADDR_W-1:IDX_W+2];

    // Byte-offset bits never select anything; fold them away here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cm_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Write FSM next-state: collect AW and W in any order, commit on the second.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_axi.S_AXI_AWADDR;
                end
                if (w_fire) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axi.S_AXI_WDATA;
                    wstrb_d  = s_axi.S_AXI_WSTRB;
                end
                if (aw_done_d && w_done_d) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = cm_ok ? RESP_OKAY : RESP_SLVERR;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    // Ready rises out of reset and drops once its beat is held.
                    awready_d = !aw_done_d;
                    wready_d  = !w_done_d;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Register bank update: byte-masked write and pulse on an accepted commit.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit && cm_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) begin
                    regs_d[cm_idx][8*b +: 8] = cm_data[8*b +: 8];
                end
            end
            wr_pulse_d[cm_idx] = 1'b1;
        end
    end

    // Register bank storage.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Read FSM next-state: capture data at the AR handshake, hold until RREADY.
    // regs_q is the pre-commit value, so a same-edge write is not visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    if (ar_oor) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rdata_d = (ar_idx == '0) ? status_in : regs_q[ar_idx];
                        rresp_d = RESP_OKAY;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Flat register view; slice 0 is the status word and is not stored here.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        if (k == 0) begin : g_zero
            assign regs_out[31:0] = '0;
        end else begin : g_reg
            assign regs_out[32*k +: 32] = regs_q[k];
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse        = wr_pulse_q;
    assign w_state_dbg         = w_state_q;
    assign r_state_dbg         = r_state_q;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for the AXI4-Lite register file: writes with strobes and
// ordering variations, status/out-of-range reads, backpressure and reset abort.
module tb_axi4_lite_slave_regfile;
    logic         clk;
    logic         rst_n;
    logic [31:0]  status_in;
    logic [511:0] regs_out;
    logic [15:0]  reg_wr_pulse;
    logic         w_state_dbg;
    logic         r_state_dbg;
    logic [511:0] exp_flat;

    int checks   = 0;
    int failures = 0;

    axi4_lite_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_slave_regfile #(
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi        (bus),
        .status_in    (status_in),
        .regs_out     (regs_out),
        .reg_wr_pulse (reg_wr_pulse),
        .w_state_dbg  (w_state_dbg),
        .r_state_dbg  (r_state_dbg)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write with AW and W presented together; called at a negedge in W_IDLE.
    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp,
                             input logic [15:0] exp_pulse);
        chk({tag, "_awready"}, 512'(bus.S_AXI_AWREADY), 512'(1));
        chk({tag, "_wready"},  512'(bus.S_AXI_WREADY),  512'(1));
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk({tag, "_bvalid"}, 512'(bus.S_AXI_BVALID), 512'(1));
        chk({tag, "_bresp"},  512'(bus.S_AXI_BRESP),  512'(exp_resp));
        chk({tag, "_pulse"},  512'(reg_wr_pulse),     512'(exp_pulse));
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk({tag, "_bvalid_done"}, 512'(bus.S_AXI_BVALID), 512'(0));
        chk({tag, "_pulse_done"},  512'(reg_wr_pulse),     512'(0));
    endtask

    // Single read; called at a negedge in R_IDLE.
    task automatic axi_read(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        chk({tag, "_arready"}, 512'(bus.S_AXI_ARREADY), 512'(1));
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        chk({tag, "_rvalid"},  512'(bus.S_AXI_RVALID),  512'(1));
        chk({tag, "_rdata"},   512'(bus.S_AXI_RDATA),   512'(exp_data));
        chk({tag, "_rresp"},   512'(bus.S_AXI_RRESP),   512'(exp_resp));
        chk({tag, "_arready_busy"}, 512'(bus.S_AXI_ARREADY), 512'(0));
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        chk({tag, "_rvalid_done"}, 512'(bus.S_AXI_RVALID), 512'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 512'(bus.S_AXI_AWREADY), 512'(0));
        chk({tag, "_wready"},  512'(bus.S_AXI_WREADY),  512'(0));
        chk({tag, "_bvalid"},  512'(bus.S_AXI_BVALID),  512'(0));
        chk({tag, "_bresp"},   512'(bus.S_AXI_BRESP),   512'(0));
        chk({tag, "_arready"}, 512'(bus.S_AXI_ARREADY), 512'(0));
        chk({tag, "_rvalid"},  512'(bus.S_AXI_RVALID),  512'(0));
        chk({tag, "_rdata"},   512'(bus.S_AXI_RDATA),   512'(0));
        chk({tag, "_rresp"},   512'(bus.S_AXI_RRESP),   512'(0));
        chk({tag, "_regs"},    regs_out,                512'(0));
        chk({tag, "_pulse"},   512'(reg_wr_pulse),      512'(0));
        chk({tag, "_wstate"},  512'(w_state_dbg),       512'(0));
        chk({tag, "_rstate"},  512'(r_state_dbg),       512'(0));
    endtask

    initial begin
        rst_n             = 1'b0;
        status_in         = 32'h0A5A_0001;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        exp_flat          = '0;

        // Reset state
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_awready", 512'(bus.S_AXI_AWREADY), 512'(1));
        chk("post_reset_arready", 512'(bus.S_AXI_ARREADY), 512'(1));

        // Index 3 full-word write, AW and W together
        axi_write("wr3", 32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 2'b00, 16'h0008);
        chk("wr3_regs127_96", 512'(regs_out[127:96]), 512'(32'hDEAD_BEEF));
        chk("wr3_awready_again", 512'(bus.S_AXI_AWREADY), 512'(1));

        // Index 5 preset, then strobed write with W three cycles ahead of AW
        axi_write("wr5a", 32'h0000_0014, 32'h1122_3344, 4'hF, 2'b00, 16'h0020);
        bus.S_AXI_WDATA  = 32'hAABB_CCDD;
        bus.S_AXI_WSTRB  = 4'b0101;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w_first_wready_low", 512'(bus.S_AXI_WREADY),  512'(0));
            chk("w_first_awready_hi", 512'(bus.S_AXI_AWREADY), 512'(1));
            chk("w_first_no_bvalid",  512'(bus.S_AXI_BVALID),  512'(0));
            if (i < 2) @(negedge clk);
        end
        bus.S_AXI_AWADDR  = 32'h0000_0014;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        chk("wr5b_bvalid", 512'(bus.S_AXI_BVALID), 512'(1));
        chk("wr5b_bresp",  512'(bus.S_AXI_BRESP),  512'(0));
        chk("wr5b_wstate", 512'(w_state_dbg),      512'(1));
        chk("wr5b_pulse",  512'(reg_wr_pulse),     512'(16'h0020));
        chk("wr5b_reg5",   512'(regs_out[191:160]), 512'(32'h11BB_33DD));
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("wr5b_bvalid_done", 512'(bus.S_AXI_BVALID), 512'(0));

        // Status read and rejected write to index 0
        axi_read("rd0", 32'h0000_0000, 32'h0A5A_0001, 2'b00);
        axi_write("wr0", 32'h0000_0000, 32'h1234_5678, 4'hF, 2'b10, 16'h0000);

        // Out-of-range address
        exp_flat[127:96]  = 32'hDEAD_BEEF;
        exp_flat[191:160] = 32'h11BB_33DD;
        axi_write("wr_oor", 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 2'b10, 16'h0000);
        chk("wr_oor_regs", regs_out, exp_flat);
        axi_read("rd_oor", 32'h0000_0100, 32'h0000_0000, 2'b10);
        axi_read("rd3", 32'h0000_000F, 32'hDEAD_BEEF, 2'b00);

        // Same-edge write and read of index 3 with both responses back-pressured
        bus.S_AXI_AWADDR  = 32'h0000_000C;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'hCAFE_F00D;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 32'h0000_000C;
        bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid",  512'(bus.S_AXI_BVALID),  512'(1));
            chk("hold_bresp",   512'(bus.S_AXI_BRESP),   512'(0));
            chk("hold_rvalid",  512'(bus.S_AXI_RVALID),  512'(1));
            chk("hold_rdata",   512'(bus.S_AXI_RDATA),   512'(32'hDEAD_BEEF));
            chk("hold_readies", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'(0));
            @(negedge clk);
        end
        chk("hold_reg3_new", 512'(regs_out[127:96]), 512'(32'hCAFE_F00D));
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        chk("hold_bvalid_done", 512'(bus.S_AXI_BVALID), 512'(0));
        chk("hold_rvalid_done", 512'(bus.S_AXI_RVALID), 512'(0));
        chk("hold_readies_back", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'(3'b111));

        // Reset asserted with both FSMs holding responses
        bus.S_AXI_AWADDR  = 32'h0000_0008;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'h0BAD_0BAD;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 32'h0000_0014;
        bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        chk("pre_abort_bvalid", 512'(bus.S_AXI_BVALID), 512'(1));
        chk("pre_abort_rvalid", 512'(bus.S_AXI_RVALID), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort_bvalid",  512'(bus.S_AXI_BVALID),  512'(0));
        chk("after_abort_rvalid",  512'(bus.S_AXI_RVALID),  512'(0));
        chk("after_abort_awready", 512'(bus.S_AXI_AWREADY), 512'(1));
        chk("after_abort_arready", 512'(bus.S_AXI_ARREADY), 512'(1));
        axi_write("wr2", 32'h0000_0008, 32'h55AA_55AA, 4'hF, 2'b00, 16'h0004);
        axi_read("rd2", 32'h0000_0008, 32'h55AA_55AA, 2'b00);
        exp_flat          = '0;
        exp_flat[95:64]   = 32'h55AA_55AA;
        chk("final_regs", regs_out, exp_flat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
